// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle radix-2 restoring DIV/DIVU sequencer with HI/LO write strobes
module div_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              signed_i,
    input  logic [DATA_W-1:0] opdata1_i,
    input  logic [DATA_W-1:0] opdata2_i,
    input  logic              cancel_i,
    input  logic              ex_hold_i,
    output logic              stallreq_o,
    output logic              ready_o,
    output logic              hi_we_o,
    output logic              lo_we_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);
    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
    typedef enum logic [1:0] {IDLE, ON, BYZERO, END} state_t;
    state_t state, nxt;
    logic [CW-1:0] cnt;
    logic [2*DATA_W:0] work, shifted;
    logic [DATA_W:0] trial;
    logic [DATA_W-1:0] dvs, a_abs, b_abs, q, r;
    logic neg_q, neg_r, was_end, go;
    assign go      = state == IDLE && start_i && !cancel_i;
    assign a_abs   = (signed_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    assign b_abs   = (signed_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
    assign shifted = work << 1;
    assign trial   = shifted[2*DATA_W:DATA_W] - {1'b0, dvs};
    assign q       = work[DATA_W-1:0];
    assign r       = work[2*DATA_W-1:DATA_W];
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = go ? ((opdata2_i == '0) ? BYZERO : ON) : IDLE;
            ON:      nxt = cancel_i ? IDLE : ((cnt == LAST) ? END : ON);
            BYZERO:  nxt = cancel_i ? IDLE : END;
            END:     nxt = ex_hold_i ? END : IDLE;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            work    <= '0;
            dvs     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            was_end <= 1'b0;
        end else begin
            was_end <= state == END;
            if (go) begin
                cnt   <= '0;
                work  <= {(DATA_W + 1)'(0), a_abs};
                dvs   <= b_abs;
                neg_q <= signed_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                neg_r <= signed_i && opdata1_i[DATA_W-1];
            end else if (state == ON) begin
                cnt  <= cnt + 1'b1;
                work <= trial[DATA_W] ? shifted : {trial, shifted[DATA_W-1:1], 1'b1};
            end else if (state == BYZERO) begin
                work <= '0;
            end
        end
    end
    // strobes fire only on the cycle END is entered, however long it is held
    assign ready_o    = state == END;
    assign hi_we_o    = ready_o && !was_end;
    assign lo_we_o    = ready_o && !was_end;
    assign lo_o       = ready_o ? (neg_q ? -q : q) : '0;
    assign hi_o       = ready_o ? (neg_r ? -r : r) : '0;
    assign stallreq_o = !cancel_i && (go || state == ON || state == BYZERO);
endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed plus random divide operations checked against an arithmetic model
module tb_div_ctrl;
    logic clk = 1'b0;
    logic rst, start, sgn, cancel, hold;
    logic [31:0] a, b;
    logic stallreq, ready, hi_we, lo_we;
    logic [31:0] hi, lo;
    int n_cmp = 0;
    int n_err = 0;

    div_ctrl #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .start_i(start), .signed_i(sgn),
        .opdata1_i(a), .opdata2_i(b), .cancel_i(cancel), .ex_hold_i(hold),
        .stallreq_o(stallreq), .ready_o(ready), .hi_we_o(hi_we), .lo_we_o(lo_we),
        .hi_o(hi), .lo_o(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [31:0] da, input logic [31:0] db, input logic ds,
                         output logic [31:0] eq, output logic [31:0] er);
        int sa, sb;
        sa = da;
        sb = db;
        if (db == 0) begin
            eq = 0; er = 0;
        end else if (!ds) begin
            eq = da / db; er = da % db;
        end else if (da == 32'h8000_0000 && db == 32'hFFFF_FFFF) begin
            eq = 32'h8000_0000; er = 0;
        end else begin
            eq = sa / sb; er = sa % sb;
        end
    endtask

    // called at a negedge with the DUT idle; leaves start high afterwards when keep is set
    task automatic run_op(input logic [31:0] da, input logic [31:0] db, input logic ds,
                          input int nh, input logic keep);
        logic [31:0] eq, er;
        int lat, cyc, stalls;
        bit seen;
        model(da, db, ds, eq, er);
        lat = (db == 0) ? 2 : 33;
        a = da; b = db; sgn = ds; start = 1'b1;
        cyc = 0; stalls = 0; seen = 0;
        while (cyc < 100) begin
            #1;
            if (ready) begin
                seen = 1;
                break;
            end
            if (stallreq) stalls++;
            @(negedge clk);
            cyc++;
        end
        chk("reached_end", 32'(seen), 1);
        chk("latency", cyc, lat);
        chk("stall_cycles", stalls, lat);
        chk("stall_in_end", 32'(stallreq), 0);
        chk("lo", lo, eq);
        chk("hi", hi, er);
        chk("strobes_first", {30'b0, hi_we, lo_we}, 3);
        start = keep;
        for (int i = 0; i < nh; i++) begin
            hold = 1'b1;
            @(negedge clk);
            #1;
            chk("ready_held", 32'(ready), 1);
            chk("strobes_held", {30'b0, hi_we, lo_we}, 0);
            chk("lo_held", lo, eq);
            chk("hi_held", hi, er);
        end
        hold = 1'b0;
        @(negedge clk);
        #1;
        chk("ready_after", 32'(ready), 0);
        chk("strobes_after", {30'b0, hi_we, lo_we}, 0);
        chk("outs_after", lo | hi, 0);
    endtask

    initial begin
        int pulses;
        logic [31:0] ra, rb;
        rst = 1'b1; start = 0; sgn = 0; cancel = 0; hold = 0; a = 0; b = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_outs", lo | hi, 0);
        chk("rst_flags", {28'b0, stallreq, ready, hi_we, lo_we}, 0);
        rst = 1'b0;
        @(negedge clk);
        run_op(100, 7, 0, 0, 0);
        run_op(-32'sd7, 2, 1, 0, 0);
        run_op(7, -32'sd2, 1, 0, 0);
        run_op(5, 0, 1, 0, 0);
        // cancel in the middle of a divide
        a = 1000; b = 3; sgn = 0; start = 1'b1;
        repeat (10) @(negedge clk);
        cancel = 1'b1; start = 1'b0;
        #1;
        chk("stall_on_cancel", 32'(stallreq), 0);
        @(negedge clk);
        cancel = 1'b0;
        #1;
        chk("cancel_idle", {30'b0, ready, stallreq}, 0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (hi_we || lo_we || ready) pulses++;
        end
        chk("cancel_no_strobe", pulses, 0);
        run_op(9, 4, 0, 0, 0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1, 3, 0);
        run_op(10, 3, 0, 0, 1);
        run_op(20, 6, 0, 0, 0);
        // reset in the middle of a divide
        a = 20; b = 6; sgn = 0; start = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_outs", lo | hi, 0);
        chk("midrst_flags", {28'b0, stallreq, ready, hi_we, lo_we}, 0);
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = $urandom;
                1: rb = $urandom_range(1, 50);
                2: rb = 0;
                default: rb = 32'hFFFF_FFFF;
            endcase
            run_op(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
